// File: rtl/graph_scheduler.sv
// Top-level sequencer for the arbitrage graph engine: commits buffered edge updates
// to adjmat, then runs the bellman, cycle and print engines in order with a per-phase watchdog.
module graph_scheduler #(
    parameter int VW      = 4,
    parameter int WW      = 32,
    parameter int DW      = 64,
    parameter int FIFO_LG = 3,
    parameter int REV_EN  = 1,
    parameter int TIMEOUT = 65535
) (
    input  logic            clk,
    input  logic            sched_reset,
    input  logic            upd_valid,
    output logic            upd_ready,
    input  logic [VW-1:0]   upd_src,
    input  logic [VW-1:0]   upd_dst,
    input  logic [WW-1:0]   upd_w,
    input  logic            run_req,
    output logic [2:0]      eng_start,
    input  logic [2:0]      eng_done,
    input  logic [3*VW-1:0] eng_adj_row,
    input  logic [3*VW-1:0] eng_adj_col,
    input  logic [3*VW-1:0] eng_vm_addr_a,
    input  logic [3*VW-1:0] eng_vm_addr_b,
    input  logic [3*DW-1:0] eng_vm_data_b,
    input  logic [2:0]      eng_vm_we_b,
    output logic [VW-1:0]   adj_row,
    output logic [VW-1:0]   adj_col,
    output logic [WW-1:0]   adj_data,
    output logic            adj_we,
    output logic [VW-1:0]   vm_addr_a,
    output logic [VW-1:0]   vm_addr_b,
    output logic [DW-1:0]   vm_data_b,
    output logic            vm_we_b,
    output logic            busy,
    output logic            run_done,
    output logic            abort,
    output logic [1:0]      abort_phase
);
    localparam int DEPTH = 1 << FIFO_LG;
    localparam logic [FIFO_LG:0]   CNT_FULL = {1'b1, {FIFO_LG{1'b0}}};
    localparam logic [FIFO_LG:0]   CNT_ONE  = {{FIFO_LG{1'b0}}, 1'b1};
    localparam logic [FIFO_LG-1:0] PTR_ONE  = {{(FIFO_LG-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE, S_WR_FWD, S_WR_REV, S_START, S_GAP, S_RUN, S_DONE, S_ABORT
    } state_t;

    state_t             state_r, state_nxt_s;
    logic [1:0]         phase_r;
    logic [31:0]        wdog_r;
    logic               pending_r, abort_r;
    logic [1:0]         abort_phase_r;

    logic [VW-1:0]      fifo_src_r [DEPTH];
    logic [VW-1:0]      fifo_dst_r [DEPTH];
    logic [WW-1:0]      fifo_w_r   [DEPTH];
    logic [FIFO_LG-1:0] wr_ptr_r, rd_ptr_r;
    logic [FIFO_LG:0]   count_r;
    logic               push_s, pop_s, empty_s;

    assign upd_ready   = (count_r != CNT_FULL);
    assign empty_s     = (count_r == {(FIFO_LG+1){1'b0}});
    assign push_s      = upd_valid && upd_ready;
    assign pop_s       = (state_r == S_WR_REV) || ((state_r == S_WR_FWD) && (REV_EN == 0));
    assign busy        = (state_r != S_IDLE);
    assign run_done    = (state_r == S_DONE);
    assign abort       = abort_r;
    assign abort_phase = abort_phase_r;

    // FIFO storage; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_src_r[wr_ptr_r] <= upd_src;
            fifo_dst_r[wr_ptr_r] <= upd_dst;
            fifo_w_r[wr_ptr_r]   <= upd_w;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (sched_reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // State register plus phase, watchdog, pending-run and abort bookkeeping.
    always_ff @(posedge clk) begin
        if (sched_reset) begin
            state_r       <= S_IDLE;
            phase_r       <= 2'd0;
            wdog_r        <= 32'd0;
            pending_r     <= 1'b0;
            abort_r       <= 1'b0;
            abort_phase_r <= 2'd0;
        end else begin
            state_r <= state_nxt_s;
            case (state_r)
                S_START: wdog_r <= 32'd0;
                S_RUN:   wdog_r <= wdog_r + 32'd1;
                default: wdog_r <= wdog_r;
            endcase
            if (state_r == S_IDLE)
                phase_r <= 2'd0;
            else if (state_r == S_RUN && eng_done[phase_r] && phase_r != 2'd2)
                phase_r <= phase_r + 2'd1;
            if (run_req)
                pending_r <= 1'b1;
            else if (state_r == S_DONE || state_r == S_ABORT)
                pending_r <= 1'b0;
            // Expiry beats a same-cycle run_req so a timeout is never silently lost.
            if (state_r == S_RUN && state_nxt_s == S_ABORT) begin
                abort_r       <= 1'b1;
                abort_phase_r <= phase_r;
            end else if (run_req) begin
                abort_r <= 1'b0;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (!empty_s)       state_nxt_s = S_WR_FWD;
                else if (pending_r) state_nxt_s = S_START;
                else                state_nxt_s = S_IDLE;
            end
            S_WR_FWD: state_nxt_s = (REV_EN != 0) ? S_WR_REV : S_IDLE;
            S_WR_REV: state_nxt_s = S_IDLE;
            S_START:  state_nxt_s = S_GAP;
            S_GAP:    state_nxt_s = S_RUN;
            S_RUN: begin
                if (eng_done[phase_r])             state_nxt_s = (phase_r == 2'd2) ? S_DONE : S_START;
                else if (wdog_r >= 32'(TIMEOUT))   state_nxt_s = S_ABORT;
                else                               state_nxt_s = S_RUN;
            end
            S_DONE:   state_nxt_s = S_IDLE;
            S_ABORT:  state_nxt_s = S_IDLE;
            default:  state_nxt_s = S_IDLE;
        endcase
    end

    // Start pulses and memory-port multiplexing.
    always_comb begin
        eng_start = 3'b000;
        adj_row   = '0;
        adj_col   = '0;
        adj_data  = '0;
        adj_we    = 1'b0;
        vm_addr_a = '0;
        vm_addr_b = '0;
        vm_data_b = '0;
        vm_we_b   = 1'b0;
        case (state_r)
            S_WR_FWD: begin
                adj_we   = 1'b1;
                adj_row  = fifo_src_r[rd_ptr_r];
                adj_col  = fifo_dst_r[rd_ptr_r];
                adj_data = fifo_w_r[rd_ptr_r];
            end
            S_WR_REV: begin
                adj_we   = 1'b1;
                adj_row  = fifo_dst_r[rd_ptr_r];
                adj_col  = fifo_src_r[rd_ptr_r];
                adj_data = {WW{1'b0}} - fifo_w_r[rd_ptr_r];
            end
            S_START: eng_start = 3'b001 << phase_r;
            S_RUN: begin
                vm_addr_a = eng_vm_addr_a[phase_r*VW +: VW];
                vm_addr_b = eng_vm_addr_b[phase_r*VW +: VW];
                vm_data_b = eng_vm_data_b[phase_r*DW +: DW];
                vm_we_b   = eng_vm_we_b[phase_r];
                // The print engine has no adjmat access.
                if (phase_r != 2'd2) begin
                    adj_row = eng_adj_row[phase_r*VW +: VW];
                    adj_col = eng_adj_col[phase_r*VW +: VW];
                end else begin
                    adj_row = '0;
                    adj_col = '0;
                end
            end
            default: eng_start = 3'b000;
        endcase
    end
endmodule
